chimera_memisland_port_arb: RTL

CHIMERA_MEMISLAND_PORT_ARB -- requirements
Module: chimera_memisland_port_arb

---
 rtl/chimera_pkg.sv | 13 +
 rtl/chimera_memisland_arb_tag_fifo.sv | 62 ++++++
 rtl/chimera_memisland_port_arb.sv | 133 +++++++++++++
 3 files changed

// File: rtl/chimera_pkg.sv
// Shared types and defaults for the memory-island port arbiter.
// Arbiter state encoding and default sizing constants.
package chimera_pkg;

  localparam int unsigned DefNumReq  = 4;
  localparam int unsigned DefMaxTxns = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/chimera_memisland_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each outstanding burst.
// Head is the owner of the oldest burst still awaiting its response.
import chimera_pkg::*;

module chimera_memisland_arb_tag_fifo #(
  parameter int unsigned Depth = DefMaxTxns,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;

  assign full_o  = (cnt_q == (AW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  // Pointer and occupancy update; pointers wrap since depth is 2^n.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/chimera_memisland_port_arb.sv
// Round-robin burst arbiter sharing one memory-island wide port.
// Burst owners are queued so responses route back in order.
import chimera_pkg::*;

module chimera_memisland_port_arb #(
  parameter int unsigned NumReq  = DefNumReq,
  parameter int unsigned MaxTxns = DefMaxTxns
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq-1:0]         req_last_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      mem_valid_o,
  output logic                      mem_last_o,
  input  logic                      mem_ready_i,
  output logic [$clog2(NumReq)-1:0] mem_sel_o,
  input  logic                      rsp_valid_i,
  input  logic                      rsp_last_i,
  output logic                      rsp_ready_o,
  output logic [NumReq-1:0]         rsp_valid_o,
  input  logic [NumReq-1:0]         rsp_ready_i,
  output logic                      err_o
);

  localparam int unsigned W = $clog2(NumReq);

  arb_state_e state_q, state_d;
  logic [W-1:0] owner_q, owner_d;
  logic [W-1:0] rr_q, rr_d;
  logic         err_q, err_d;

  logic [W-1:0] pick;
  logic         pick_vld;
  logic [W-1:0] idx;

  logic         push, pop;
  logic         full, empty;
  logic [W-1:0] head;

  assign mem_sel_o = owner_q;
  assign err_o     = err_q;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      idx = W'((32'(rr_q) + i) % NumReq);
      if (!pick_vld && req_valid_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // Grant FSM and request-path muxing; ownership held until last beat.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    push        = 1'b0;
    mem_valid_o = 1'b0;
    mem_last_o  = 1'b0;
    req_ready_o = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_vld && !full) begin
          owner_d = pick;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        mem_valid_o          = req_valid_i[owner_q];
        mem_last_o           = req_last_i[owner_q];
        req_ready_o[owner_q] = mem_ready_i;
        if (mem_valid_o && mem_ready_i && mem_last_o) begin
          push    = 1'b1;
          state_d = ST_IDLE;
          rr_d    = (owner_q == W'(NumReq - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response routing to the oldest owner; stray beats are dropped.
  always_comb begin
    rsp_valid_o = '0;
    rsp_ready_o = 1'b0;
    pop         = 1'b0;
    err_d       = err_q;
    if (!empty) begin
      rsp_valid_o[head] = rsp_valid_i;
      rsp_ready_o       = rsp_ready_i[head];
      pop = rsp_valid_i && rsp_ready_i[head] && rsp_last_i;
    end else if (rsp_valid_i) begin
      rsp_ready_o = 1'b1;
      err_d       = 1'b1;
    end
  end

  // Arbiter state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  chimera_memisland_arb_tag_fifo #(
    .Depth (MaxTxns),
    .Width (W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (owner_q),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

endmodule
